// File: rtl/fractcam_pkg.sv
// Shared types and width helpers for the FracTCAM write/update path.
package fractcam_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_DEL = 1'b0;
    localparam logic OP_WR  = 1'b1;

    function automatic int unsigned slices(input int unsigned key_width, input int unsigned slice_width);
        return key_width / slice_width;
    endfunction

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fractcam_slice_enc.sv
// Match bit for one LUTRAM slice: address matches key on every cared-for bit.
module fractcam_slice_enc #(
    parameter int unsigned SLICE_WIDTH = 5
) (
    input  logic [SLICE_WIDTH-1:0] addr,
    input  logic [SLICE_WIDTH-1:0] key_s,
    input  logic [SLICE_WIDTH-1:0] mask_s,
    output logic                   match_c
);

    assign match_c = ((addr ^ key_s) & mask_s) == '0;

endmodule

// File: rtl/fractcam_wr.sv
// FracTCAM write/update controller: turns one write/delete command into a
// full LUTRAM address sweep and maintains the entry-valid bitmap.
module fractcam_wr
    import fractcam_pkg::*;
#(
    parameter int unsigned KEY_WIDTH   = 40,
    parameter int unsigned SLICE_WIDTH = 5,
    parameter int unsigned DEPTH       = 64,
    localparam int unsigned SLICES     = slices(KEY_WIDTH, SLICE_WIDTH),
    localparam int unsigned IDX_W      = idx_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_op,
    input  logic [IDX_W-1:0]       s_idx,
    input  logic [KEY_WIDTH-1:0]   s_key,
    input  logic [KEY_WIDTH-1:0]   s_mask,
    output logic                   m_wr_en,
    output logic [SLICE_WIDTH-1:0] m_wr_addr,
    output logic [IDX_W-1:0]       m_wr_idx,
    output logic [SLICES-1:0]      m_wr_data,
    output logic [DEPTH-1:0]       entry_vld,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [SLICE_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [IDX_W:0]         DEPTH_W = (IDX_W+1)'(DEPTH);

    state_t                 state_q, state_d;
    logic [SLICE_WIDTH-1:0] cnt_q, cnt_d;
    logic                   op_q, op_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [KEY_WIDTH-1:0]   mask_q, mask_d;

    logic                   wr_en_d;
    logic [SLICE_WIDTH-1:0] wr_addr_d;
    logic [IDX_W-1:0]       wr_idx_d;
    logic [SLICES-1:0]      wr_data_d;
    logic [DEPTH-1:0]       vld_d;
    logic                   busy_d, done_d, err_d;

    logic [SLICE_WIDTH-1:0] enc_addr;
    logic [KEY_WIDTH-1:0]   enc_key, enc_mask;
    logic [SLICES-1:0]      match;
    logic                   idx_oor;

    assign s_ready = (state_q == IDLE);
    assign idx_oor = ({1'b0, s_idx} >= DEPTH_W);

    // Encoders evaluate the address/key that the next strobe will carry,
    // so the write data can be registered alongside the address.
    always_comb begin
        enc_addr = '0;
        enc_key  = key_q;
        enc_mask = mask_q;
        if (state_q == IDLE) begin
            enc_key  = s_key;
            enc_mask = s_mask;
        end else begin
            enc_addr = cnt_q + SLICE_WIDTH'(1);
        end
    end

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        fractcam_slice_enc #(
            .SLICE_WIDTH (SLICE_WIDTH)
        ) u_enc (
            .addr    (enc_addr),
            .key_s   (enc_key[s*SLICE_WIDTH +: SLICE_WIDTH]),
            .mask_s  (enc_mask[s*SLICE_WIDTH +: SLICE_WIDTH]),
            .match_c (match[s])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        idx_d     = idx_q;
        key_d     = key_q;
        mask_d    = mask_q;
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_idx_d  = '0;
        wr_data_d = '0;
        vld_d     = entry_vld;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_valid) begin
                    op_d   = s_op;
                    idx_d  = s_idx;
                    key_d  = s_key;
                    mask_d = s_mask;
                    if (idx_oor) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = SWEEP;
                        cnt_d     = '0;
                        wr_en_d   = 1'b1;
                        wr_idx_d  = s_idx;
                        wr_data_d = (s_op == OP_WR) ? match : '0;
                    end
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + SLICE_WIDTH'(1);
                if (cnt_q == CNT_MAX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_d;
                    wr_idx_d  = idx_q;
                    wr_data_d = (op_q == OP_WR) ? match : '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                // Rejected commands never touch the bitmap.
                if (!err) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (idx_q == IDX_W'(i)) vld_d[i] = op_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= 1'b0;
            idx_q     <= '0;
            key_q     <= '0;
            mask_q    <= '0;
            m_wr_en   <= 1'b0;
            m_wr_addr <= '0;
            m_wr_idx  <= '0;
            m_wr_data <= '0;
            entry_vld <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            key_q     <= key_d;
            mask_q    <= mask_d;
            m_wr_en   <= wr_en_d;
            m_wr_addr <= wr_addr_d;
            m_wr_idx  <= wr_idx_d;
            m_wr_data <= wr_data_d;
            entry_vld <= vld_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_fractcam_wr.sv
// Self-checking bench for fractcam_wr (KEY_WIDTH=40, SLICE_WIDTH=5, DEPTH=48).
module tb_fractcam_wr;

    localparam int unsigned KW    = 40;
    localparam int unsigned SW    = 5;
    localparam int unsigned DEPTH = 48;
    localparam int unsigned NS    = KW / SW;
    localparam int unsigned IW    = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic          s_op;
    logic [IW-1:0] s_idx;
    logic [KW-1:0] s_key;
    logic [KW-1:0] s_mask;
    logic          m_wr_en;
    logic [SW-1:0] m_wr_addr;
    logic [IW-1:0] m_wr_idx;
    logic [NS-1:0] m_wr_data;
    logic [DEPTH-1:0] entry_vld;
    logic          busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;
    logic [DEPTH-1:0] model_vld = '0;

    fractcam_wr #(
        .KEY_WIDTH   (KW),
        .SLICE_WIDTH (SW),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_op      (s_op),
        .s_idx     (s_idx),
        .s_key     (s_key),
        .s_mask    (s_mask),
        .m_wr_en   (m_wr_en),
        .m_wr_addr (m_wr_addr),
        .m_wr_idx  (m_wr_idx),
        .m_wr_data (m_wr_data),
        .entry_vld (entry_vld),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: slice s stores a 1 at address a when every cared-for key bit equals the address bit.
    function automatic logic [NS-1:0] exp_data(input int a, input logic op,
                                               input logic [KW-1:0] key, input logic [KW-1:0] mask);
        logic [NS-1:0] d;
        logic [SW-1:0] av;
        av = SW'(a);
        d  = '0;
        if (op) begin
            for (int s = 0; s < NS; s++) begin
                d[s] = 1'b1;
                for (int b = 0; b < SW; b++)
                    if (mask[s*SW+b] && (av[b] != key[s*SW+b])) d[s] = 1'b0;
            end
        end
        return d;
    endfunction

    task automatic do_cmd(input logic op, input logic [IW-1:0] idx, input logic [KW-1:0] key,
                          input logic [KW-1:0] mask, input bit hold, input int abort_at);
        @(negedge clk);
        s_valid = 1'b1;
        s_op    = op;
        s_idx   = idx;
        s_key   = key;
        s_mask  = mask;
        chk("ready_before_accept", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        if (!hold) begin
            s_valid = 1'b0;
            s_op    = 1'($urandom);
            s_idx   = IW'($urandom);
            s_key   = KW'({$urandom, $urandom});
            s_mask  = KW'({$urandom, $urandom});
        end
        if (int'(idx) >= int'(DEPTH)) begin
            chk("oor_wr_en", 64'(m_wr_en), 64'd0);
            chk("oor_done", 64'(done), 64'd1);
            chk("oor_err", 64'(err), 64'd1);
            chk("oor_vld", 64'(entry_vld), 64'(model_vld));
            @(posedge clk);
            #1;
            chk("oor_done_clear", 64'(done), 64'd0);
            chk("oor_ready", 64'(s_ready), 64'd1);
            return;
        end
        for (int a = 0; a < 32; a++) begin
            if (a == abort_at) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                model_vld = '0;
                chk("abort_wr_en", 64'(m_wr_en), 64'd0);
                chk("abort_outs", 64'({m_wr_addr, m_wr_idx, m_wr_data, busy, done, err}), 64'd0);
                chk("abort_vld", 64'(entry_vld), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                chk("abort_ready", 64'(s_ready), 64'd1);
                return;
            end
            chk("sweep_wr_en", 64'(m_wr_en), 64'd1);
            chk("sweep_addr", 64'(m_wr_addr), 64'(a));
            chk("sweep_idx", 64'(m_wr_idx), 64'(idx));
            chk("sweep_data", 64'(m_wr_data), 64'(exp_data(a, op, key, mask)));
            chk("sweep_ctrl", 64'({s_ready, busy, done}), 64'b010);
            chk("sweep_vld", 64'(entry_vld), 64'(model_vld));
            @(posedge clk);
            #1;
        end
        chk("done_pulse", 64'({done, err, m_wr_en, s_ready, busy}), 64'b10001);
        chk("done_outs_zero", 64'({m_wr_addr, m_wr_idx, m_wr_data}), 64'd0);
        chk("done_vld_old", 64'(entry_vld), 64'(model_vld));
        model_vld[idx] = op;
        @(posedge clk);
        #1;
        chk("idle_vld_new", 64'(entry_vld), 64'(model_vld));
        chk("idle_ctrl", 64'({s_ready, busy, done, err}), 64'b1000);
    endtask

    initial begin
        logic [KW-1:0] rk, rm;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_op    = 1'b0;
        s_idx   = '0;
        s_key   = '0;
        s_mask  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", 64'({m_wr_en, m_wr_addr, m_wr_idx, m_wr_data, busy, done, err}), 64'd0);
        chk("rst_vld", 64'(entry_vld), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_ready", 64'(s_ready), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_wr_en", 64'(m_wr_en), 64'd0);
        chk("post_rst_vld", 64'(entry_vld), 64'd0);

        do_cmd(1'b1, 6'd3, 40'h00_0000_0005, '1, 1'b0, -1);
        do_cmd(1'b1, 6'd0, 40'h12_3456_789A, '0, 1'b0, -1);
        do_cmd(1'b0, 6'd3, 40'h00_0000_0005, '1, 1'b0, -1);

        do_cmd(1'b1, 6'd50, 40'hAB_CDEF_0123, '1, 1'b0, -1);
        do_cmd(1'b1, 6'd48, 40'h0, '1, 1'b0, -1);
        do_cmd(1'b1, 6'd47, 40'hFF_00FF_00FF, 40'h0F_F0F0_0FF0, 1'b0, -1);

        rk = KW'({$urandom, $urandom});
        rm = KW'({$urandom, $urandom});
        do_cmd(1'b1, 6'd10, rk, rm, 1'b1, -1);
        do_cmd(1'b0, 6'd47, rk, rm, 1'b0, -1);

        do_cmd(1'b1, 6'd20, rk, rm, 1'b0, 9);
        chk("post_abort_vld", 64'(entry_vld), 64'd0);

        for (int n = 0; n < 24; n++) begin
            rk = KW'({$urandom, $urandom});
            case ($urandom % 4)
                0:       rm = '0;
                1:       rm = '1;
                default: rm = KW'({$urandom, $urandom});
            endcase
            do_cmd(1'($urandom), IW'($urandom_range(0, 55)), rk, rm, 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
